// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 core memory path.
// Holds default bus widths and the response-owner encoding.
// Imported by the arbiter and by any block that decodes owner tags.
package mips32_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // Which port issued a memory command.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Tag that travels with a command until its read data returns.
    typedef struct packed {
        logic   vld;
        owner_t own;
    } rsp_tag_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between fetch and data ports, with data priority and fetch anti-starvation.
// Latency: a grant at edge N puts the command on mem_* in cycle N+1; read data returns with rvalid in cycle N+2.
// Backpressure: a request is held until its combinational gnt; one grant per cycle, back-to-back with no bubbles.
module mem_arbiter
    import mips32_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt;
    logic              starve_hit;
    rsp_tag_t          tag_s1;
    rsp_tag_t          tag_s2;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Grant select: data wins unless fetch has waited STARVE_MAX data grants; nothing granted during reset.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if_gnt = if_req && (!dm_req || starve_hit);
            dm_gnt = dm_req && !if_gnt;
        end
    end

    // Count data grants taken while fetch waits; any fetch grant or idle fetch port clears it.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (dm_gnt && !starve_hit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Register the granted command onto the memory port; fetches are always reads.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= if_gnt || dm_gnt;
            mem_we <= dm_gnt && dm_we;
            if (dm_gnt) begin
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (if_gnt) begin
                mem_addr  <= if_addr;
            end
        end
    end

    // Two-stage owner tag; a flush voids every fetch read still in flight, including one granted this cycle.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1.vld <= (if_gnt && !if_flush) || (dm_gnt && !dm_we);
            tag_s1.own <= dm_gnt ? OWN_DM : OWN_IF;
            tag_s2.vld <= tag_s1.vld && !(if_flush && (tag_s1.own == OWN_IF));
            tag_s2.own <= tag_s1.own;
        end
    end

    assign if_rvalid = tag_s2.vld && (tag_s2.own == OWN_IF);
    assign dm_rvalid = tag_s2.vld && (tag_s2.own == OWN_DM);

    // Capture each delivered word so rdata holds its last valid value between responses.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (dm_rvalid) dm_rdata_q <= mem_rdata;
        end
    end

    // Memory data passes straight through in the response cycle, otherwise the held copy.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency memory model.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_mem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              if_req, if_flush, dm_req, dm_we;
    logic [ADDR_W-1:0] if_addr, dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DATA_W-1:0] if_rdata, dm_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk1(clk1), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk1 = ~clk1;

    // Memory model: preload, then synchronous write / read with 1-cycle read latency.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[5]    = 32'h2001_0004;
        mem_rdata = '0;
        forever begin
            @(posedge clk1);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata     <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic mid();
        @(negedge clk1);
    endtask

    // Both requests held for n cycles; fetch expected every 5th grant when started from a cleared counter.
    task automatic pattern(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            logic exp_if;
            exp_if = ((i % 5) == 4);
            mid();
            chk($sformatf("%s_if_gnt_%0d", tag, i), {31'd0, if_gnt}, {31'd0, exp_if});
            chk($sformatf("%s_dm_gnt_%0d", tag, i), {31'd0, dm_gnt}, {31'd0, !exp_if});
            step();
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = '0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Reset state, with a fetch request present that must not be granted.
        step(); mid();
        chk("rst_if_gnt",    {31'd0, if_gnt},    32'd0);
        chk("rst_dm_gnt",    {31'd0, dm_gnt},    32'd0);
        chk("rst_mem_en",    {31'd0, mem_en},    32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  {22'd0, mem_addr},  32'd0);
        chk("rst_mem_wdata", mem_wdata,          32'd0);
        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
        chk("rst_if_rdata",  if_rdata,           32'd0);
        chk("rst_dm_rdata",  dm_rdata,           32'd0);
        step(); if_req = 1'b0; rst = 1'b0;

        // Single fetch from address 5.
        step(); if_req = 1'b1; if_addr = 10'd5;
        mid();  chk("f_if_gnt", {31'd0, if_gnt}, 32'd1);
                chk("f_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        step(); if_req = 1'b0;
        mid();  chk("f_mem_en",   {31'd0, mem_en},    32'd1);
                chk("f_mem_we",   {31'd0, mem_we},    32'd0);
                chk("f_mem_addr", {22'd0, mem_addr},  32'd5);
                chk("f_rv_c1",    {31'd0, if_rvalid}, 32'd0);
        step(); mid();
                chk("f_rvalid",   {31'd0, if_rvalid}, 32'd1);
                chk("f_rdata",    if_rdata,           32'h2001_0004);
                chk("f_dm_rv",    {31'd0, dm_rvalid}, 32'd0);
        step(); mid();
                chk("f_rv_pulse", {31'd0, if_rvalid}, 32'd0);
                chk("f_rd_hold",  if_rdata,           32'h2001_0004);
                chk("f_mem_idle", {31'd0, mem_en},    32'd0);

        // Store then load of address 12, back to back.
        step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd12; dm_wdata = 32'hDEAD_BEEF;
        mid();  chk("sw_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step(); dm_we = 1'b0; dm_wdata = 32'h0;
        mid();  chk("lw_dm_gnt",    {31'd0, dm_gnt},   32'd1);
                chk("sw_mem_en",    {31'd0, mem_en},   32'd1);
                chk("sw_mem_we",    {31'd0, mem_we},   32'd1);
                chk("sw_mem_addr",  {22'd0, mem_addr}, 32'd12);
                chk("sw_mem_wdata", mem_wdata,         32'hDEAD_BEEF);
        step(); dm_req = 1'b0;
        mid();  chk("lw_mem_en",  {31'd0, mem_en},    32'd1);
                chk("lw_mem_we",  {31'd0, mem_we},    32'd0);
                chk("sw_no_rv",   {31'd0, dm_rvalid}, 32'd0);
        step(); mid();
                chk("lw_rvalid",  {31'd0, dm_rvalid}, 32'd1);
                chk("lw_rdata",   dm_rdata,           32'hDEAD_BEEF);
                chk("lw_no_if",   {31'd0, if_rvalid}, 32'd0);
        step(); mid();
                chk("lw_rv_pulse", {31'd0, dm_rvalid}, 32'd0);
                chk("lw_rd_hold",  dm_rdata,           32'hDEAD_BEEF);

        // Contention: fetch addr 7 versus data stores to addr 20.
        step(); if_req = 1'b1; if_addr = 10'd7; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd20;
        #0 pattern("starve", 10);
        // Three data grants, then fetch idles for one cycle which clears the count.
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid(); chk($sformatf("pre_dm_gnt_%0d", i), {31'd0, dm_gnt}, 32'd1);
            step();
        end
        if_req = 1'b0;
        mid();  chk("clr_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step(); if_req = 1'b1;
        pattern("clr", 5);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        step(); step(); step();
        mid();  chk("fetch7_hold", if_rdata, 32'h1000_0007);

        // Fetch granted, flushed next edge alongside a data load that must still return.
        step(); if_req = 1'b1; if_addr = 10'd5;
        mid();  chk("fl_if_gnt", {31'd0, if_gnt}, 32'd1);
        step(); if_req = 1'b0; if_flush = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd12;
        mid();  chk("fl_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step(); if_flush = 1'b0; dm_req = 1'b0;
        mid();  chk("fl_no_if_rv", {31'd0, if_rvalid}, 32'd0);
                chk("fl_if_hold",  if_rdata,           32'h1000_0007);
        step(); mid();
                chk("fl_dm_rv",    {31'd0, dm_rvalid}, 32'd1);
                chk("fl_dm_rdata", dm_rdata,           32'hDEAD_BEEF);
                chk("fl_no_if_rv2", {31'd0, if_rvalid}, 32'd0);

        // Reset pulsed the cycle after a data load grant.
        step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd12;
        mid();  chk("rl_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step(); dm_req = 1'b0; rst = 1'b1;
        mid();  chk("rl_mem_en",   {31'd0, mem_en},   32'd0);
                chk("rl_mem_addr", {22'd0, mem_addr}, 32'd0);
                chk("rl_dm_rdata", dm_rdata,          32'd0);
                chk("rl_if_rdata", if_rdata,          32'd0);
        step(); rst = 1'b0;
        mid();  chk("rl_no_rv_a", {31'd0, dm_rvalid}, 32'd0);
        step(); mid();
                chk("rl_no_rv_b", {31'd0, dm_rvalid}, 32'd0);
                chk("rl_dm_rd0",  dm_rdata,           32'd0);
        // Counter cleared by reset: full four data grants before fetch.
        step(); if_req = 1'b1; if_addr = 10'd3; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd30;
        pattern("post_rst", 5);
        if_req = 1'b0; dm_req = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
